// File: rtl/instr_prefetch_queue.sv
// Instruction prefetch queue: fetches words over a req/ack handshake into a
// small FIFO and presents the head word to the decompressor.
module instr_prefetch_queue #(
  parameter int unsigned      WIDTH    = 32,
  parameter int unsigned      DEPTH    = 4,
  parameter logic [WIDTH-1:0] PCADD    = WIDTH'(4),
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             reset,
  output logic             memReq,
  output logic [WIDTH-1:0] memAddr,
  input  logic             memAck,
  input  logic [WIDTH-1:0] memData,
  output logic [WIDTH-1:0] NextInstr,
  output logic [WIDTH-1:0] headPC,
  output logic             instrValid,
  input  logic             consume,
  input  logic             redirect,
  input  logic [WIDTH-1:0] redirectPC
);

  localparam int unsigned     AW   = $clog2(DEPTH);
  localparam int unsigned     CW   = AW + 1;
  localparam logic [CW-1:0]   FULL = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DROP
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] fetch_addr, fetch_nxt;
  logic [WIDTH-1:0] addr_nxt, addr_inc;
  logic [WIDTH-1:0] data_q [DEPTH];
  logic [WIDTH-1:0] pc_q   [DEPTH];
  logic [AW-1:0]    rptr, wptr, rptr_nxt, wptr_nxt;
  logic [CW-1:0]    count, count_nxt;
  logic [WIDTH-1:0] head_data_nxt, head_pc_nxt;
  logic             push, pop;

  assign memReq     = (state != IDLE);
  assign instrValid = (count != '0);
  assign addr_inc   = memAddr + PCADD;

  // Redirect wins over both push and pop.
  always_comb begin
    push      = (state == REQ) && memAck && !redirect;
    pop       = consume && (count != '0) && !redirect;
    count_nxt = count + CW'(push) - CW'(pop);
    rptr_nxt  = rptr + AW'(pop);
    wptr_nxt  = wptr + AW'(push);
    if (redirect) begin
      count_nxt = '0;
      rptr_nxt  = '0;
      wptr_nxt  = '0;
    end
  end

  always_comb begin
    state_nxt = state;
    fetch_nxt = fetch_addr;
    addr_nxt  = memAddr;
    unique case (state)
      IDLE: begin
        if (redirect) begin
          fetch_nxt = redirectPC;
        end else if (count < FULL) begin
          addr_nxt  = fetch_addr;
          state_nxt = REQ;
        end
      end
      REQ: begin
        if (redirect) begin
          fetch_nxt = redirectPC;
          state_nxt = memAck ? IDLE : DROP;
        end else if (memAck) begin
          fetch_nxt = addr_inc;
          if (count_nxt < FULL) addr_nxt = addr_inc;
          else state_nxt = IDLE;
        end
      end
      DROP: begin
        if (redirect) fetch_nxt = redirectPC;
        if (memAck) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Head view: bypass the incoming word when it lands at the new head slot.
  always_comb begin
    head_data_nxt = NextInstr;
    head_pc_nxt   = headPC;
    if (!redirect && count_nxt != '0) begin
      if (push && wptr == rptr_nxt) begin
        head_data_nxt = memData;
        head_pc_nxt   = memAddr;
      end else begin
        head_data_nxt = data_q[rptr_nxt];
        head_pc_nxt   = pc_q[rptr_nxt];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      fetch_addr <= RESET_PC;
      memAddr    <= '0;
      rptr       <= '0;
      wptr       <= '0;
      count      <= '0;
      NextInstr  <= '0;
      headPC     <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        data_q[i] <= '0;
        pc_q[i]   <= '0;
      end
    end else begin
      state      <= state_nxt;
      fetch_addr <= fetch_nxt;
      memAddr    <= addr_nxt;
      rptr       <= rptr_nxt;
      wptr       <= wptr_nxt;
      count      <= count_nxt;
      NextInstr  <= head_data_nxt;
      headPC     <= head_pc_nxt;
      if (push) begin
        data_q[wptr] <= memData;
        pc_q[wptr]   <= memAddr;
      end
    end
  end

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Bench for instr_prefetch_queue: directed scenarios plus a random run
// against a queue-based reference model.
module tb_instr_prefetch_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        memReq, memAck, consume, redirect, instrValid;
  logic [31:0] memAddr, memData, NextInstr, headPC, redirectPC;

  always #5 clk = ~clk;

  instr_prefetch_queue #(
    .WIDTH(32), .DEPTH(4), .PCADD(32'h4), .RESET_PC(32'h100)
  ) dut (
    .clk(clk), .reset(reset),
    .memReq(memReq), .memAddr(memAddr),
    .memAck(memAck), .memData(memData),
    .NextInstr(NextInstr), .headPC(headPC),
    .instrValid(instrValid), .consume(consume),
    .redirect(redirect), .redirectPC(redirectPC)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: queue of {data, pc}, plus fetch bookkeeping.
  logic [63:0] q[$];
  logic [31:0] m_fetch, m_addr, m_hd, m_hp;
  bit          m_req, m_drop;

  task automatic model_reset();
    q.delete();
    m_fetch = 32'h100;
    m_addr  = '0;
    m_hd    = '0;
    m_hp    = '0;
    m_req   = 0;
    m_drop  = 0;
  endtask

  task automatic model_step();
    int n;
    n = q.size();
    if (redirect) begin
      q.delete();
      m_fetch = redirectPC;
      if (m_req) begin
        if (memAck) begin
          m_req  = 0;
          m_drop = 0;
        end else begin
          m_drop = 1;
        end
      end
    end else begin
      if (consume && n > 0) void'(q.pop_front());
      if (m_req && m_drop) begin
        if (memAck) begin
          m_req  = 0;
          m_drop = 0;
        end
      end else if (m_req) begin
        if (memAck) begin
          q.push_back({memData, m_addr});
          m_fetch = m_addr + 32'h4;
          if (q.size() < 4) m_addr = m_fetch;
          else m_req = 0;
        end
      end else if (n < 4) begin
        m_addr = m_fetch;
        m_req  = 1;
      end
    end
    if (q.size() > 0) begin
      m_hd = q[0][63:32];
      m_hp = q[0][31:0];
    end
  endtask

  function automatic logic [97:0] expv();
    return {m_req, m_addr, q.size() != 0, m_hd, m_hp};
  endfunction

  task automatic tick(bit ack, bit cons, bit redir,
                      logic [31:0] rpc, logic [31:0] data);
    memAck     = ack;
    consume    = cons;
    redirect   = redir;
    redirectPC = rpc;
    memData    = data;
    @(posedge clk);
    model_step();
    @(negedge clk);
    memAck   = 0;
    consume  = 0;
    redirect = 0;
  endtask

  task automatic test_reset();
    reset = 0; memAck = 0; consume = 0; redirect = 0;
    redirectPC = '0; memData = '0;
    model_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({memReq, memAddr, instrValid, NextInstr, headPC} !== 98'd0) begin
      errors++;
      $display("FAIL reset_outs: got %h want 0",
               {memReq, memAddr, instrValid, NextInstr, headPC});
    end
    reset = 1;
  endtask

  task automatic test_fill();
    logic [31:0] acks[$];
    logic [31:0] first;
    bit got_first = 0;
    for (int i = 0; i < 10; i++) begin
      logic [31:0] d;
      bit a;
      d = $urandom;
      a = memReq;
      if (a) acks.push_back(memAddr);
      if (a && !got_first) begin
        first = d;
        got_first = 1;
      end
      tick(a, 0, 0, '0, d);
      checks++;
      if ({memReq, memAddr, instrValid, NextInstr, headPC} !== expv()) begin
        errors++;
        $display("FAIL fill_cyc%0d: got %h want %h", i,
                 {memReq, memAddr, instrValid, NextInstr, headPC}, expv());
      end
    end
    checks++;
    if (acks.size() != 4) begin
      errors++;
      $display("FAIL fill_acks: got %0d want 4", acks.size());
    end
    for (int i = 0; i < acks.size() && i < 4; i++) begin
      checks++;
      if (acks[i] !== 32'h100 + 32'(4 * i)) begin
        errors++;
        $display("FAIL fill_addr%0d: got %h want %h", i, acks[i],
                 32'h100 + 32'(4 * i));
      end
    end
    checks++;
    if ({memReq, instrValid, NextInstr, headPC} !==
        {1'b0, 1'b1, first, 32'h100}) begin
      errors++;
      $display("FAIL fill_head: got %h want %h",
               {memReq, instrValid, NextInstr, headPC},
               {1'b0, 1'b1, first, 32'h100});
    end
  endtask

  task automatic test_consume_one();
    tick(0, 1, 0, '0, $urandom);
    checks++;
    if (headPC !== 32'h104 || memReq !== 1'b0) begin
      errors++;
      $display("FAIL pop_head: got pc=%h req=%b want pc=104 req=0",
               headPC, memReq);
    end
    tick(0, 0, 0, '0, $urandom);
    checks++;
    if (memReq !== 1'b1 || memAddr !== 32'h110) begin
      errors++;
      $display("FAIL refill_req: got req=%b addr=%h want req=1 addr=110",
               memReq, memAddr);
    end
  endtask

  task automatic test_redirect_drop();
    logic [31:0] d;
    tick(0, 0, 1, 32'h200, $urandom);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({memReq, memAddr, instrValid} !== {1'b1, 32'h110, 1'b0}) begin
        errors++;
        $display("FAIL drop_hold%0d: got req=%b addr=%h v=%b want 1 110 0",
                 i, memReq, memAddr, instrValid);
      end
      if (i < 2) tick(0, 0, 0, '0, $urandom);
    end
    tick(1, 0, 0, '0, $urandom);
    checks++;
    if (memReq !== 1'b0 || instrValid !== 1'b0) begin
      errors++;
      $display("FAIL drop_done: got req=%b v=%b want 0 0", memReq, instrValid);
    end
    tick(0, 0, 0, '0, $urandom);
    checks++;
    if (memReq !== 1'b1 || memAddr !== 32'h200) begin
      errors++;
      $display("FAIL drop_newreq: got req=%b addr=%h want 1 200",
               memReq, memAddr);
    end
    d = $urandom;
    tick(1, 0, 0, '0, d);
    checks++;
    if ({instrValid, NextInstr, headPC} !== {1'b1, d, 32'h200}) begin
      errors++;
      $display("FAIL drop_first: got %h want %h",
               {instrValid, NextInstr, headPC}, {1'b1, d, 32'h200});
    end
  endtask

  task automatic test_redirect_ack();
    tick(1, 0, 1, 32'h40, $urandom);
    checks++;
    if (memReq !== 1'b0 || instrValid !== 1'b0) begin
      errors++;
      $display("FAIL rack_idle: got req=%b v=%b want 0 0", memReq, instrValid);
    end
    tick(0, 0, 0, '0, $urandom);
    checks++;
    if (memReq !== 1'b1 || memAddr !== 32'h40) begin
      errors++;
      $display("FAIL rack_req: got req=%b addr=%h want 1 40", memReq, memAddr);
    end
    tick(1, 0, 0, '0, $urandom);
    checks++;
    if (headPC !== 32'h40 || instrValid !== 1'b1) begin
      errors++;
      $display("FAIL rack_head: got pc=%h v=%b want 40 1", headPC, instrValid);
    end
  endtask

  task automatic test_back_to_back();
    tick(1, 0, 0, '0, $urandom);
    for (int k = 1; k <= 10; k++) begin
      tick(1, 1, 0, '0, $urandom);
      checks++;
      if ({memReq, instrValid, headPC, q.size()} !==
          {1'b1, 1'b1, 32'h40 + 32'(4 * k), 32'd2} ||
          {memReq, memAddr, instrValid, NextInstr, headPC} !== expv()) begin
        errors++;
        $display("FAIL b2b_k%0d: got req=%b v=%b pc=%h want 1 1 %h (model %h)",
                 k, memReq, instrValid, headPC, 32'h40 + 32'(4 * k), expv());
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      bit a, c, r;
      a = memReq && ($urandom_range(0, 9) < 6);
      c = ($urandom_range(0, 1) == 1);
      r = ($urandom_range(0, 99) < 4);
      tick(a, c, r, 32'($urandom_range(0, 1023)) << 2, $urandom);
      checks++;
      if ({memReq, memAddr, instrValid, NextInstr, headPC} !== expv()) begin
        errors++;
        $display("FAIL rand_cyc%0d: got %h want %h", i,
                 {memReq, memAddr, instrValid, NextInstr, headPC}, expv());
      end
    end
  endtask

  task automatic test_async_reset();
    tick(1, 0, 1, 32'h300, $urandom);
    tick(0, 0, 0, '0, $urandom);
    checks++;
    if (memReq !== 1'b1 || memAddr !== 32'h300) begin
      errors++;
      $display("FAIL ar_pre: got req=%b addr=%h want 1 300", memReq, memAddr);
    end
    #2 reset = 0;
    #1;
    model_reset();
    checks++;
    if ({memReq, memAddr, instrValid} !== {1'b0, 32'h0, 1'b0}) begin
      errors++;
      $display("FAIL ar_async: got req=%b addr=%h v=%b want 0 0 0",
               memReq, memAddr, instrValid);
    end
    @(negedge clk);
    reset = 1;
    tick(0, 1, 0, '0, $urandom);
    checks++;
    if ({memReq, memAddr, instrValid} !== {1'b1, 32'h100, 1'b0}) begin
      errors++;
      $display("FAIL ar_restart: got req=%b addr=%h v=%b want 1 100 0",
               memReq, memAddr, instrValid);
    end
    tick(1, 1, 0, '0, $urandom);
    checks++;
    if ({instrValid, headPC} !== {1'b1, 32'h100} ||
        {memReq, memAddr, instrValid, NextInstr, headPC} !== expv()) begin
      errors++;
      $display("FAIL ar_first: got v=%b pc=%h want 1 100", instrValid, headPC);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_fill();
    test_consume_one();
    test_redirect_drop();
    test_redirect_ack();
    test_back_to_back();
    test_random();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
